fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 190 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage that sits directly after the program counter
// register. It keeps the fetch PC and issues in-order word requests to
// instruction memory over a valid/ready handshake. Returned words are tagged
// with their address and buffered in a DEPTH-entry FIFO that feeds decode.
// A single-cycle redirect (branch/jump) reloads the PC, empties the FIFO and
// arranges for every response still in flight to be discarded on arrival.
//
// Flow control is credit based. Every request still in flight, whether it
// will be kept (r_outstanding) or thrown away (r_drop_cnt), and every
// buffered entry (r_count) holds one credit. A new request is issued only
// while fewer than DEPTH credits are in use. This guarantees that a response
// always finds a free FIFO slot. It also keeps r_drop_cnt at or below DEPTH,
// even when redirects arrive back to back.
//
// Ports
//   clock            in   1   rising-edge clock
//   reset            in   1   synchronous, active-high reset
//   redirect_valid   in   1   load redirect_pc and flush the pipe this cycle
//   redirect_pc      in  64   new fetch address (bits [1:0] ignored)
//   imem_req_valid   out  1   request to instruction memory
//   imem_req_ready   in   1   memory accepts the request
//   imem_req_addr    out 64   request byte address, 4-aligned
//   imem_resp_valid  in   1   response this cycle (in order, no backpressure)
//   imem_resp_data   in  32   instruction word
//   dec_valid        out  1   FIFO head valid
//   dec_ready        in   1   decode consumes the head
//   dec_instr        out 32   head instruction (0 when empty)
//   dec_pc           out 64   address of the head instruction (0 when empty)
//   pc_out           out 64   current fetch PC (next address to request)
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'd0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_instr,
   output logic [63:0] dec_pc,
   output logic [63:0] pc_out
);

   localparam int AW = $clog2(DEPTH);   // FIFO pointer width
   localparam int CW = AW + 1;          // counters hold 0..DEPTH
   localparam int UW = CW + 2;          // sum of three counters, no overflow

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [63:0]   r_fetch_pc;           // next address to request
   logic [63:0]   r_resp_pc;            // address of the next kept response
   logic [CW-1:0] r_outstanding;        // in flight, will be kept
   logic [CW-1:0] r_drop_cnt;           // in flight, will be discarded
   logic [CW-1:0] r_count;              // FIFO occupancy
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [31:0]   r_fifo_instr [DEPTH];
   logic [63:0]   r_fifo_pc    [DEPTH];

   // ---------------------------------------------------------------------
   // Handshakes and derived controls
   // ---------------------------------------------------------------------
   logic [UW-1:0] w_used;
   logic          w_credit;
   logic          w_req_fire;
   logic          w_resp_drop;
   logic          w_resp_take;
   logic          w_push;
   logic          w_pop;
   logic          w_fifo_empty;
   logic          w_fifo_full;
   logic [63:0]   w_redirect_pc;
   logic [UW-1:0] w_drop_on_redirect;
   logic [1:0]    w_unused_redirect_lsbs;

   assign w_used   = UW'(r_outstanding) + UW'(r_drop_cnt) + UW'(r_count);
   assign w_credit = (w_used < UW'(DEPTH));

   // The request depends only on registered state and reset, never on
   // redirect_valid. A request that fires alongside a redirect therefore
   // carries the old address and is counted for dropping.
   assign imem_req_valid = !reset && w_credit;
   assign imem_req_addr  = r_fetch_pc;
   assign pc_out         = r_fetch_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   // A response either pays off a pending drop or is a kept instruction.
   assign w_resp_drop = imem_resp_valid && (r_drop_cnt != '0);
   assign w_resp_take = imem_resp_valid && (r_drop_cnt == '0);

   assign w_fifo_empty = (r_count == '0);
   assign w_fifo_full  = (r_count == CW'(DEPTH));

   // A kept response that lands in a redirect cycle is stale and is not stored.
   assign w_push = w_resp_take && !redirect_valid;
   assign w_pop  = !w_fifo_empty && dec_ready;

   assign w_redirect_pc          = {redirect_pc[63:2], 2'b00};
   assign w_unused_redirect_lsbs = redirect_pc[1:0];

   // On a redirect, every request still in flight becomes a drop, including
   // one firing this cycle. Any response arriving this cycle, dropped or
   // kept, retires one of them.
   assign w_drop_on_redirect = UW'(r_drop_cnt) + UW'(r_outstanding)
                             + UW'(w_req_fire) - UW'(imem_resp_valid);

   // ---------------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc    <= w_redirect_pc;
         r_resp_pc     <= w_redirect_pc;
         r_outstanding <= '0;
         r_drop_cnt    <= CW'(w_drop_on_redirect);
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
      end else begin
         if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + 64'd4;
         end
         if (w_resp_take) begin
            r_resp_pc <= r_resp_pc + 64'd4;
         end
         r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_resp_take);
         if (w_resp_drop) begin
            r_drop_cnt <= r_drop_cnt - CW'(1);
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // ---------------------------------------------------------------------
   // FIFO storage
   // ---------------------------------------------------------------------
   // NOTE: the storage array has no reset. Entries are never observed until
   // written, because dec_valid/dec_instr/dec_pc are qualified by r_count.
   always_ff @(posedge clock) begin
      if (!reset && w_push) begin
         r_fifo_instr[r_wr_ptr] <= imem_resp_data;
         r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
      end
   end

   // No bypass: an entry pushed into an empty FIFO shows up the next cycle.
   assign dec_valid = !w_fifo_empty;
   assign dec_instr = dec_valid ? r_fifo_instr[r_rd_ptr] : 32'd0;
   assign dec_pc    = dec_valid ? r_fifo_pc[r_rd_ptr]    : 64'd0;

   // ---------------------------------------------------------------------
   // Invariants of the credit scheme
   // ---------------------------------------------------------------------
   a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      !(w_push && w_fifo_full));

   a_no_spurious_resp: assert property (@(posedge clock) disable iff (reset)
      imem_resp_valid |-> ((r_outstanding != '0) || (r_drop_cnt != '0)));

   a_credit_bound: assert property (@(posedge clock) disable iff (reset)
      w_used <= UW'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Scoreboard bench for fetch_unit (DEPTH = 4, RESET_PC = 0).
//
// Each request the memory accepts pushes an expected {pc, instr} pair, built
// from the bench's own PC model, onto exp_q. A redirect or a reset empties
// exp_q. A monitor pops and compares on every decode handshake.
//
// The memory model answers in order with a configurable latency. It returns
// addr[31:0] as data. It can stall its responses, and it discards pending
// responses on reset.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'd0;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'd0;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [31:0] dec_instr;
   logic [63:0] dec_pc;
   logic [63:0] pc_out;

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clock           (clock),
      .reset           (reset),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .dec_valid       (dec_valid),
      .dec_ready       (dec_ready),
      .dec_instr       (dec_instr),
      .dec_pc          (dec_pc),
      .pc_out          (pc_out)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } exp_t;

   typedef struct {
      logic [63:0] addr;
      int unsigned due;
   } mem_t;

   exp_t        exp_q[$];
   mem_t        mem_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_fires  = 0;
   int unsigned cyc      = 0;
   logic [63:0] model_pc = RESET_PC;
   logic [63:0] last_fire_addr = 64'd0;

   // Memory configuration, owned by the stimulus process.
   bit mem_stall       = 1'b0;
   bit mem_ready_rand  = 1'b0;
   bit mem_ready_fixed = 1'b0;
   int mem_lat_min     = 1;
   int mem_lat_max     = 1;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Waits (bounded) for the FIFO head, then checks its address.
   task automatic expect_head(input string name, input logic [63:0] pc);
      bit seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (dec_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
      else       check(name, dec_pc, pc);
      tick();
   endtask

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // ---------------------------------------------------------------------
   // Instruction memory model
   // ---------------------------------------------------------------------
   initial begin
      int unsigned lat;
      int unsigned due;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'd0;
      forever begin
         @(negedge clock);
         if (reset) begin
            mem_q.delete();
         end else if (imem_req_valid && imem_req_ready) begin
            lat = $urandom_range(mem_lat_max, mem_lat_min);
            due = cyc + lat;
            if (mem_q.size() > 0 && due <= mem_q[$].due) due = mem_q[$].due + 1;
            mem_q.push_back('{imem_req_addr, due});
         end
         @(posedge clock);
         #2;
         imem_req_ready  = mem_ready_rand ? 1'($urandom_range(1, 0)) : mem_ready_fixed;
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'd0;
         if (!mem_stall && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_q[0].addr[31:0];
            void'(mem_q.pop_front());
         end
      end
   end

   // ---------------------------------------------------------------------
   // Scoreboard monitor
   // ---------------------------------------------------------------------
   initial begin
      exp_t e;
      bit   fire;
      forever begin
         @(negedge clock);
         if (reset) begin
            exp_q.delete();
            model_pc = RESET_PC;
         end else begin
            check("pc_out", pc_out, model_pc);
            check("imem_req_addr", imem_req_addr, model_pc);
            check("unexpected_dec_valid",
                  {63'd0, dec_valid && (exp_q.size() == 0)}, 64'd0);
            if (dec_valid && dec_ready && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("dec_pc", dec_pc, e.pc);
               check("dec_instr", {32'd0, dec_instr}, {32'd0, e.instr});
            end
            fire = imem_req_valid && imem_req_ready;
            if (fire) begin
               n_fires++;
               last_fire_addr = imem_req_addr;
            end
            if (redirect_valid) begin
               exp_q.delete();
               model_pc = {redirect_pc[63:2], 2'b00};
            end else if (fire) begin
               exp_q.push_back('{model_pc, model_pc[31:0]});
               model_pc = model_pc + 64'd4;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------
   // Directed and random stimulus
   // ---------------------------------------------------------------------
   initial begin
      int n0;
      logic [63:0] wrap_pcs [4];
      wrap_pcs[0] = 64'hFFFF_FFFF_FFFF_FFF8;
      wrap_pcs[1] = 64'hFFFF_FFFF_FFFF_FFFC;
      wrap_pcs[2] = 64'h0;
      wrap_pcs[3] = 64'h4;

      // Reset state and streaming at one instruction per cycle.
      mem_ready_fixed = 1'b1;
      dec_ready       = 1'b1;
      tick();
      @(negedge clock);
      check("reset_req_valid", {63'd0, imem_req_valid}, 64'd0);
      do_reset();
      @(negedge clock);
      check("reset_dec_valid", {63'd0, dec_valid}, 64'd0);
      check("reset_dec_instr", {32'd0, dec_instr}, 64'd0);
      check("reset_dec_pc", dec_pc, 64'd0);
      check("reset_pc_out", pc_out, RESET_PC);
      tick();
      tick();
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         check("stream_dec_valid", {63'd0, dec_valid}, 64'd1);
         check("stream_dec_pc", dec_pc, 64'(4 * i));
         check("stream_dec_instr", {32'd0, dec_instr}, 64'(4 * i));
         check("stream_pc_out", pc_out, 64'(8 + 4 * i));
         tick();
      end

      // Backpressure from decode: the credit limit caps requests at DEPTH.
      dec_ready = 1'b0;
      do_reset();
      n0 = n_fires;
      repeat (12) tick();
      check("bp_fire_count", 64'(n_fires - n0), 64'd4);
      @(negedge clock);
      check("bp_req_valid_low", {63'd0, imem_req_valid}, 64'd0);
      tick();
      n0 = n_fires;
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      repeat (6) tick();
      check("bp_refill_count", 64'(n_fires - n0), 64'd1);
      check("bp_refill_addr", last_fire_addr, 64'h10);

      // Redirect with 2 buffered and 2 in flight.
      mem_stall = 1'b1;
      do_reset();
      repeat (8) tick();
      mem_stall = 1'b0;
      tick();
      tick();
      mem_stall      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h1000;
      tick();
      redirect_valid = 1'b0;
      mem_stall      = 1'b0;
      dec_ready      = 1'b1;
      @(negedge clock);
      check("redir_fifo_empty", {63'd0, dec_valid}, 64'd0);
      expect_head("redir_first_pc", 64'h1000);
      repeat (6) tick();

      // Redirect near the top of the address space, with nonzero low bits.
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFA;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 4; i++) expect_head("wrap_dec_pc", wrap_pcs[i]);

      // Reset mid-stream with 3 requests outstanding.
      mem_stall       = 1'b1;
      mem_ready_fixed = 1'b0;
      dec_ready       = 1'b0;
      do_reset();
      mem_ready_fixed = 1'b1;
      repeat (3) tick();
      mem_ready_fixed = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clock);
      check("midreset_dec_valid", {63'd0, dec_valid}, 64'd0);
      check("midreset_pc_out", pc_out, RESET_PC);
      tick();
      mem_stall       = 1'b0;
      mem_ready_fixed = 1'b1;
      dec_ready       = 1'b1;
      expect_head("midreset_first_pc", RESET_PC);
      repeat (10) tick();

      // Random latency, handshakes and redirects.
      mem_ready_rand = 1'b1;
      mem_lat_min    = 1;
      mem_lat_max    = 3;
      for (int i = 0; i < 10000; i++) begin
         dec_ready      = 1'($urandom_range(1, 0));
         redirect_valid = ($urandom_range(63, 0) == 0);
         if ($urandom_range(3, 0) == 0)
            redirect_pc = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(31, 0));
         else
            redirect_pc = {32'd0, $urandom};
         tick();
      end
      redirect_valid = 1'b0;

      // Drain: stop requesting and let every kept instruction reach decode.
      mem_ready_rand  = 1'b0;
      mem_ready_fixed = 1'b0;
      dec_ready       = 1'b1;
      repeat (30) tick();
      check("drain_nothing_lost", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
